// File: rtl/ex_muldiv_ctrl.sv
// ex_muldiv_ctrl
//   Sequencer for the iterative multiply/divide unit that sits beside the EX
//   stage ALU. It accepts MULT/MULTU/DIV/DIVU from EX, runs a 32-step
//   shift-add multiply or restoring divide, and owns the HI/LO registers.
//   The pipeline is stalled while an operation is computing. MTHI/MTLO
//   writes are accepted while the unit is idle.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous reset, active-high
//   start        issue request from EX, sampled only when idle
//   op           00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   opa          rs operand: multiplicand or dividend
//   opb          rt operand: multiplier or divisor
//   cancel       pipeline flush, aborts an in-flight operation
//   hi_we/lo_we  MTHI/MTLO write enables, honoured only when idle
//   wdata        MTHI/MTLO write data
//   stall_req    hold IF/ID/EX (combinational)
//   busy         unit is not idle
//   done         one-cycle pulse, HI/LO hold the new result this cycle
//   div_by_zero  set by a divide with a zero divisor, qualified by done
//   hi/lo        HI and LO architectural registers

module ex_muldiv_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  input  logic             cancel,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             stall_req,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t state;
  state_t state_next;

  logic [CNT_W-1:0]   cnt;
  logic               is_div;
  logic               neg_q;
  logic               neg_r;
  logic [WIDTH-1:0]   operand_b;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_step;

  logic               accept;
  logic               zero_div;
  logic               sign_a;
  logic               sign_b;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH:0]     add_sum;
  logic [WIDTH:0]     trial;
  logic [2*WIDTH-1:0] prod_final;
  logic [WIDTH-1:0]   quot_final;
  logic [WIDTH-1:0]   rem_final;

  // Signed ops work on magnitudes; the result signs are reapplied at the end.
  assign sign_a   = !op[0] && opa[WIDTH-1];
  assign sign_b   = !op[0] && opb[WIDTH-1];
  assign mag_a    = sign_a ? -opa : opa;
  assign mag_b    = sign_b ? -opb : opb;
  assign zero_div = op[1] && (opb == '0);
  assign accept   = (state == IDLE) && start && !cancel;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and status outputs. A flush in CALC wins over the final
  // iteration so that a cancelled operation can never commit.
  always_comb begin
    state_next = state;
    stall_req  = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        stall_req = accept;
        if (accept) begin
          state_next = zero_div ? DONE : CALC;
        end
      end
      CALC: begin
        stall_req = 1'b1;
        busy      = 1'b1;
        if (cancel) begin
          state_next = IDLE;
        end else if (cnt == LAST_CNT) begin
          state_next = DONE;
        end
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // One iteration of the shared accumulator.
  // Multiply: acc = {partial product, remaining multiplier bits}; add the
  // multiplicand into the top half when the low bit is set, then shift right.
  // Divide: acc = {partial remainder, remaining dividend / quotient bits};
  // shift left one bit, keep the trial subtraction when it does not borrow.
  always_comb begin
    add_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, operand_b};
    trial    = acc[2*WIDTH-1:WIDTH-1] - {1'b0, operand_b};
    acc_step = acc;
    if (is_div) begin
      if (!trial[WIDTH]) begin
        acc_step = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end else begin
        acc_step = {acc[2*WIDTH-2:0], 1'b0};
      end
    end else begin
      if (acc[0]) begin
        acc_step = {add_sum, acc[WIDTH-1:1]};
      end else begin
        acc_step = {1'b0, acc[2*WIDTH-1:1]};
      end
    end
  end

  // Sign fix-up of the final iteration's result.
  always_comb begin
    prod_final = neg_q ? -acc_step : acc_step;
    quot_final = neg_q ? -acc_step[WIDTH-1:0] : acc_step[WIDTH-1:0];
    rem_final  = neg_r ? -acc_step[2*WIDTH-1:WIDTH] : acc_step[2*WIDTH-1:WIDTH];
  end

  // Datapath and HI/LO. MTHI/MTLO only land while idle; a divide by zero
  // leaves HI/LO alone and only raises div_by_zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      is_div      <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      operand_b   <= '0;
      acc         <= '0;
      hi          <= '0;
      lo          <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (hi_we) begin
            hi <= wdata;
          end
          if (lo_we) begin
            lo <= wdata;
          end
          if (accept) begin
            div_by_zero <= zero_div;
            is_div      <= op[1];
            neg_q       <= sign_a ^ sign_b;
            neg_r       <= sign_a;
            cnt         <= '0;
            operand_b   <= op[1] ? mag_b : mag_a;
            acc         <= {{WIDTH{1'b0}}, (op[1] ? mag_a : mag_b)};
          end
        end
        CALC: begin
          if (!cancel) begin
            acc <= acc_step;
            if (cnt == LAST_CNT) begin
              if (is_div) begin
                lo <= quot_final;
                hi <= rem_final;
              end else begin
                hi <= prod_final[2*WIDTH-1:WIDTH];
                lo <= prod_final[WIDTH-1:0];
              end
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// tb_ex_muldiv_ctrl
//   Scoreboard bench for ex_muldiv_ctrl. Each issued operation pushes its
//   expected HI/LO/div_by_zero into a queue computed with plain SystemVerilog
//   arithmetic; a monitor pops and compares whenever done pulses.

module tb_ex_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] opa;
  logic [31:0] opb;
  logic        cancel;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        stall_req;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model_hi;
  logic [31:0] model_lo;
  int          checks = 0;
  int          errors = 0;

  ex_muldiv_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .op          (op),
    .opa         (opa),
    .opb         (opb),
    .cancel      (cancel),
    .hi_we       (hi_we),
    .lo_we       (lo_we),
    .wdata       (wdata),
    .stall_req   (stall_req),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports failures.
  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, expected);
    end
  endtask

  // Monitor: every done pulse must match the oldest pending expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        checkOutput("result_pending", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          checkOutput("hi", 64'(hi), 64'(e.hi));
          checkOutput("lo", 64'(lo), 64'(e.lo));
          checkOutput("div_by_zero", 64'(div_by_zero), 64'(e.dbz));
        end
      end
    end
  end

  // All outputs must sit at their reset values.
  task automatic checkReset(input string tag);
    checkOutput({tag, "_hi"}, 64'(hi), 64'd0);
    checkOutput({tag, "_lo"}, 64'(lo), 64'd0);
    checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
    checkOutput({tag, "_done"}, 64'(done), 64'd0);
    checkOutput({tag, "_stall"}, 64'(stall_req), 64'd0);
    checkOutput({tag, "_dbz"}, 64'(div_by_zero), 64'd0);
  endtask

  // Issue one operation (optionally with MTHI/MTLO in the same cycle), push
  // the reference result, and follow it cycle by cycle until it retires.
  task automatic applyStimulus(input logic [1:0] o, input logic [31:0] a,
                               input logic [31:0] b, input logic hw,
                               input logic lw, input logic [31:0] wd);
    exp_t        e;
    int          lat;
    int          done_cyc;
    int          guard;
    longint      sa;
    longint      sb;
    longint      p;
    longint      q;
    longint      r;
    logic [63:0] pu;

    if (hw) model_hi = wd;
    if (lw) model_lo = wd;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e.dbz = 1'b0;
    if (o[1] && b == 32'd0) begin
      e.hi  = model_hi;
      e.lo  = model_lo;
      e.dbz = 1'b1;
      lat   = 1;
    end else begin
      lat = 33;
      case (o)
        2'b00: begin
          p    = sa * sb;
          e.hi = p[63:32];
          e.lo = p[31:0];
        end
        2'b01: begin
          pu   = {32'd0, a} * {32'd0, b};
          e.hi = pu[63:32];
          e.lo = pu[31:0];
        end
        2'b10: begin
          q    = sa / sb;
          r    = sa % sb;
          e.lo = q[31:0];
          e.hi = r[31:0];
        end
        default: begin
          e.lo = a / b;
          e.hi = a % b;
        end
      endcase
    end
    model_hi = e.hi;
    model_lo = e.lo;
    exp_q.push_back(e);

    op = o; opa = a; opb = b; hi_we = hw; lo_we = lw; wdata = wd; start = 1'b1;
    done_cyc = -1;
    for (int cyc = 0; cyc <= lat; cyc++) begin
      @(negedge clk);
      checkOutput($sformatf("stall_c%0d", cyc), 64'(stall_req), 64'(cyc < lat));
      checkOutput($sformatf("busy_c%0d", cyc), 64'(busy), 64'(cyc >= 1));
      if (done === 1'b1 && done_cyc < 0) done_cyc = cyc;
      @(posedge clk); #1;
      start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    end
    checkOutput("done_latency", 64'(done_cyc), 64'(lat));

    guard = 0;
    while (busy === 1'b1 && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    checkOutput("idle_after_op", 64'(busy), 64'd0);
    checkOutput("pending_after_op", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  // Hard stop if anything hangs.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired actual=running required=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "[TB] watchdog");
  end

  logic [31:0] saved_hi;
  logic [31:0] saved_lo;
  logic [1:0]  r_op;
  logic [31:0] r_a;
  logic [31:0] r_b;

  // Main sequence: reset, directed cases, cancel, random traffic, reset mid-op.
  initial begin
    rst = 1'b1; start = 1'b0; op = 2'b00; opa = '0; opb = '0;
    cancel = 1'b0; hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    model_hi = '0; model_lo = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkReset("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    $display("[TB] directed multiply/divide");
    applyStimulus(2'b00, 32'hFFFFFFF9, 32'd3, 1'b0, 1'b0, 32'd0);
    applyStimulus(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 32'd0);
    applyStimulus(2'b10, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0, 32'd0);
    applyStimulus(2'b11, 32'd100, 32'd7, 1'b0, 1'b0, 32'd0);
    applyStimulus(2'b10, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0, 32'd0);

    $display("[TB] MTHI/MTLO then divide by zero");
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h12345678;
    @(posedge clk); #1;
    hi_we = 1'b0; lo_we = 1'b0;
    model_hi = 32'h12345678; model_lo = 32'h12345678;
    @(negedge clk);
    checkOutput("mthi", 64'(hi), 64'(model_hi));
    checkOutput("mtlo", 64'(lo), 64'(model_lo));
    @(posedge clk); #1;
    applyStimulus(2'b11, 32'd55, 32'd0, 1'b0, 1'b0, 32'd0);
    applyStimulus(2'b10, 32'd9, 32'd0, 1'b1, 1'b0, 32'hCAFEF00D);
    applyStimulus(2'b01, 32'd6, 32'd7, 1'b0, 1'b1, 32'h0BADBEEF);

    $display("[TB] cancel during CALC");
    saved_hi = model_hi; saved_lo = model_lo;
    for (int cyc = 0; cyc <= 15; cyc++) begin
      start  = (cyc == 0) || (cyc == 5);
      op     = (cyc == 5) ? 2'b11 : 2'b00;
      opa    = 32'd1234;
      opb    = 32'd5678;
      cancel = (cyc == 10);
      @(negedge clk);
      if (cyc >= 1 && cyc <= 10) checkOutput($sformatf("cancel_busy_c%0d", cyc), 64'(busy), 64'd1);
      if (cyc >= 11) checkOutput($sformatf("cancel_idle_c%0d", cyc), 64'(busy), 64'd0);
      @(posedge clk); #1;
    end
    start = 1'b0; cancel = 1'b0;
    checkOutput("cancel_hi", 64'(hi), 64'(saved_hi));
    checkOutput("cancel_lo", 64'(lo), 64'(saved_lo));

    $display("[TB] random operations");
    for (int n = 0; n < 24; n++) begin
      r_op = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 5))
        0: r_a = 32'h80000000;
        1: r_a = 32'($urandom_range(0, 20));
        default: r_a = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0: r_b = 32'd0;
        1: r_b = 32'($urandom_range(1, 15));
        2: r_b = 32'hFFFFFFFF;
        default: r_b = $urandom;
      endcase
      applyStimulus(r_op, r_a, r_b, 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), $urandom);
    end

    $display("[TB] writes while busy and reset mid-operation");
    applyStimulus(2'b01, 32'h00010001, 32'h00030003, 1'b0, 1'b0, 32'd0);
    saved_hi = model_hi; saved_lo = model_lo;
    op = 2'b00; opa = $urandom; opb = $urandom; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hA5A5A5A5;
    @(posedge clk); #1;
    hi_we = 1'b0; lo_we = 1'b0;
    @(negedge clk);
    checkOutput("busy_write_lo", 64'(lo), 64'(saved_lo));
    checkOutput("busy_write_hi", 64'(hi), 64'(saved_hi));
    checkOutput("busy_mid_calc", 64'(busy), 64'd1);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    checkReset("async_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    model_hi = '0; model_lo = '0;
    applyStimulus(2'b11, 32'd100, 32'd7, 1'b0, 1'b0, 32'd0);

    checkOutput("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
